// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: FSM state type, cycle-count helpers, frame builder
// and the command bytes used by both the host transmitter and rk_kbd.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    longint unsigned prod;
    prod = longint'(clk_hz) * longint'(us) / 64'd1_000_000;
    return int'(prod);
  endfunction

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    longint unsigned prod;
    prod = longint'(clk_hz) * longint'(ms) / 64'd1_000;
    return int'(prod);
  endfunction

  // Frame shifted out LSB first after the start bit: {stop, odd parity, d7..d0}.
  function automatic logic [9:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 clock line conditioning: 2-FF synchronizer, FILTER-sample debounce
// and a one-cycle strobe on each accepted high-to-low transition.
module ps2_line_filter #(
  parameter int unsigned FILTER = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic sync_o,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(FILTER + 1);

  logic          sync_q1;
  logic [CW-1:0] run_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_o  <= 1'b1;
      level_o <= 1'b1;
      fall_o  <= 1'b0;
      run_cnt <= '0;
    end else begin
      sync_q1 <= pin_i;
      sync_o  <= sync_q1;
      fall_o  <= 1'b0;
      // Count consecutive samples that disagree with the accepted level.
      if (sync_o != level_o) begin
        if (run_cnt == CW'(FILTER - 1)) begin
          level_o <= sync_o;
          fall_o  <= level_o & ~sync_o;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 10-bit frame,
// device ACK check and a whole-transaction timeout, open-collector drive.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_MS = 15,
  parameter int unsigned FILTER     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       err_nack,
  output logic       err_timeout
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int unsigned TIMEOUT_CYC = ms_to_cycles(CLK_HZ, TIMEOUT_MS);
  localparam int unsigned IW          = $clog2(INHIBIT_CYC + 1);
  localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);

  logic clk_sync;
  logic clk_level;
  logic clk_fall;

  ps2_line_filter #(
    .FILTER(FILTER)
  ) u_clk_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (ps2_clk_i),
    .sync_o  (clk_sync),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  logic [1:0] dat_sync_q;
  logic       dat_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dat_sync_q <= '1;
    end else begin
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  assign dat_sync = dat_sync_q[1];

  ps2_tx_state_t state;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          to_expired;

  assign to_expired = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      shreg       <= '1;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      tx_ready    <= 1'b1;
      rx_inhibit  <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_dat_oe  <= 1'b0;
      done        <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;

      if (to_expired) begin
        // Timeout overrides whatever the current state would have done,
        // including a done/err_nack that would otherwise fire this cycle.
        err_timeout <= 1'b1;
        ps2_clk_oe  <= 1'b0;
        ps2_dat_oe  <= 1'b0;
        to_cnt      <= '0;
        if (state == ST_WAIT_IDLE) begin
          state      <= ST_IDLE;
          tx_ready   <= 1'b1;
          rx_inhibit <= 1'b0;
        end else begin
          state <= ST_WAIT_IDLE;
        end
      end else begin
        if (state != ST_IDLE) begin
          to_cnt <= to_cnt + 1'b1;
        end

        unique case (state)
          ST_IDLE: begin
            if (tx_valid && tx_ready) begin
              shreg      <= build_frame(tx_data);
              bit_cnt    <= '0;
              inh_cnt    <= '0;
              to_cnt     <= '0;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
              tx_ready   <= 1'b0;
              rx_inhibit <= 1'b1;
              state      <= ST_INHIBIT;
            end
          end

          ST_INHIBIT: begin
            if (inh_cnt == IW'(INHIBIT_CYC - 1)) begin
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b1;
              state      <= ST_REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end

          ST_REQ: begin
            bit_cnt <= '0;
            state   <= ST_BITS;
          end

          ST_BITS: begin
            if (clk_fall) begin
              ps2_dat_oe <= ~shreg[0];
              shreg      <= {1'b1, shreg[9:1]};
              bit_cnt    <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) begin
                state <= ST_ACK;
              end
            end
          end

          ST_ACK: begin
            if (clk_fall) begin
              if (!dat_sync) begin
                done <= 1'b1;
              end else begin
                err_nack <= 1'b1;
              end
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b0;
              state      <= ST_WAIT_IDLE;
            end
          end

          ST_WAIT_IDLE: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            if (clk_sync && dat_sync) begin
              state      <= ST_IDLE;
              tx_ready   <= 1'b1;
              rx_inhibit <= 1'b0;
            end
          end

          default: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= ST_WAIT_IDLE;
          end
        endcase
      end
    end
  end

  logic unused_level;
  assign unused_level = clk_level;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on wired-AND lines, clock
// scaled to 1 MHz of cycles so 100 us = 100 cycles and 15 ms = 15000 cycles.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int HALF    = 40;
  localparam int INH_CYC = 100;
  localparam int TO_CYC  = 15000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       rx_inhibit, done, err_nack, err_timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       glitch_low = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = ~ps2_clk_oe & ~dev_clk_low & ~glitch_low;
  assign ps2_dat_line = ~ps2_dat_oe & ~dev_dat_low;

  always #10 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ    (1_000_000),
    .INHIBIT_US(100),
    .TIMEOUT_MS(15),
    .FILTER    (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_dat_i  (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .rx_inhibit (rx_inhibit),
    .done       (done),
    .err_nack   (err_nack),
    .err_timeout(err_timeout)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int nack_cnt = 0;
  int tmo_cnt = 0;

  logic exp_q[$];
  int   out_q[$];   // 0 = expect done, 1 = expect err_nack

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err_nack === 1'b1) nack_cnt++;
    if (err_timeout === 1'b1) tmo_cnt++;
  end

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic send_byte(input logic [7:0] d, input int outcome);
    int c = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready got=%b want=1", tx_ready);
    end
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(odd_par(d));
    exp_q.push_back(1'b1);
    out_q.push_back(outcome);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    total++;
    if (ps2_clk_oe !== 1'b1) begin
      bad++;
      $display("FAIL accept_latency clk_oe got=%b want=1", ps2_clk_oe);
    end
    @(negedge clk);
  endtask

  task automatic device_txn(input bit nack, input bit glitches, input bit busy_poke,
                            input int abort_at);
    int   inh = 0;
    int   c = 0;
    int   d0, n0, want;
    logic e;
    d0 = done_cnt;
    n0 = nack_cnt;
    while (ps2_clk_oe === 1'b1 && inh < INH_CYC + 50) begin
      inh++;
      @(negedge clk);
    end
    total++;
    if (inh != INH_CYC) begin
      bad++;
      $display("FAIL inhibit_len got=%0d want=%0d", inh, INH_CYC);
    end
    while (!(ps2_clk_line === 1'b1 && ps2_dat_line === 1'b0) && c < 50) begin
      @(negedge clk);
      c++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
    total++;
    if (ps2_dat_line !== e) begin
      bad++;
      $display("FAIL start_bit got=%b want=%b", ps2_dat_line, e);
    end
    repeat (HALF) @(negedge clk);

    for (int k = 1; k <= 10; k++) begin
      for (int t = 0; t < HALF; t++) begin
        dev_clk_low = !(glitches && t == HALF / 2);
        if (busy_poke && k == 2) begin
          tx_data  = 8'h00;
          tx_valid = (t >= 4 && t < 8);
          if (t == 6) begin
            total++;
            if (tx_ready !== 1'b0) begin
              bad++;
              $display("FAIL busy_ready got=%b want=0", tx_ready);
            end
          end
        end
        if (abort_at == k && t == HALF / 2) begin
          total++;
          if (ps2_dat_oe !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_dat_oe got=%b want=1", ps2_dat_oe);
          end
          #2 reset_n = 1'b0;
          #1;
          total++;
          if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_oe got=%b want=00", {ps2_clk_oe, ps2_dat_oe});
          end
          total++;
          if ({tx_ready, rx_inhibit} !== 2'b10) begin
            bad++;
            $display("FAIL reset_mid_ready got=%b want=10", {tx_ready, rx_inhibit});
          end
          dev_clk_low = 1'b0;
          @(negedge clk);
          @(negedge clk);
          reset_n = 1'b1;
          exp_q.delete();
          out_q.delete();
          return;
        end
        @(negedge clk);
      end
      tx_valid = 1'b0;
      dev_clk_low = 1'b0;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      total++;
      if (ps2_dat_line !== e) begin
        bad++;
        $display("FAIL frame_bit%0d got=%b want=%b", k, ps2_dat_line, e);
      end
      for (int t = 0; t < HALF; t++) begin
        glitch_low = glitches && t == HALF / 2;
        @(negedge clk);
      end
      glitch_low = 1'b0;
    end

    dev_dat_low = !nack;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    dev_dat_low = 1'b0;

    c = 0;
    while (tx_ready !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL txn_ready_return got=%b want=1", tx_ready);
    end
    want = (out_q.size() > 0) ? out_q.pop_front() : -1;
    total++;
    if ((done_cnt - d0) != ((want == 0) ? 1 : 0)) begin
      bad++;
      $display("FAIL done_pulses got=%0d want=%0d", done_cnt - d0, (want == 0) ? 1 : 0);
    end
    total++;
    if ((nack_cnt - n0) != ((want == 1) ? 1 : 0)) begin
      bad++;
      $display("FAIL nack_pulses got=%0d want=%0d", nack_cnt - n0, (want == 1) ? 1 : 0);
    end
    total++;
    if ({ps2_clk_oe, ps2_dat_oe, rx_inhibit} !== 3'b000) begin
      bad++;
      $display("FAIL lines_released got=%b want=000", {ps2_clk_oe, ps2_dat_oe, rx_inhibit});
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
      bad++;
      $display("FAIL reset_oe got=%b want=00", {ps2_clk_oe, ps2_dat_oe});
    end
    total++;
    if ({tx_ready, rx_inhibit} !== 2'b10) begin
      bad++;
      $display("FAIL reset_ready got=%b want=10", {tx_ready, rx_inhibit});
    end
    total++;
    if ({done, err_nack, err_timeout} !== 3'b000) begin
      bad++;
      $display("FAIL reset_pulses got=%b want=000", {done, err_nack, err_timeout});
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_set_led;
    send_byte(PS2_CMD_SET_LED, 0);
    device_txn(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_nack;
    send_byte(PS2_CMD_ENABLE, 1);
    device_txn(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_patterns;
    logic [7:0] pats [3];
    pats[0] = 8'h00;
    pats[1] = 8'hFF;
    pats[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      send_byte(pats[i], 0);
      device_txn(1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic test_timeout;
    int c = 0;
    int t0;
    int d0;
    t0 = tmo_cnt;
    d0 = done_cnt;
    send_byte(PS2_CMD_RESET, 2);
    exp_q.delete();
    out_q.delete();
    while (err_timeout !== 1'b1 && c < TO_CYC + 100) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c != TO_CYC) begin
      bad++;
      $display("FAIL timeout_cycles got=%0d want=%0d", c, TO_CYC);
    end
    total++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_oe got=%b want=00", {ps2_clk_oe, ps2_dat_oe});
    end
    c = 0;
    while (tx_ready !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (tx_ready !== 1'b1 || (tmo_cnt - t0) != 1 || done_cnt != d0) begin
      bad++;
      $display("FAIL timeout_end ready=%b tmo=%0d done=%0d want ready=1 tmo=1 done=0",
               tx_ready, tmo_cnt - t0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    send_byte(8'h00, 0);
    device_txn(1'b0, 1'b0, 1'b0, 4);
    repeat (20) @(negedge clk);
    send_byte(PS2_CMD_ENABLE, 0);
    device_txn(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    send_byte(8'hA6, 0);
    device_txn(1'b0, 1'b1, 1'b1, 0);
    repeat (30) @(negedge clk);
    total++;
    if ({tx_ready, ps2_clk_oe, rx_inhibit} !== 3'b100) begin
      bad++;
      $display("FAIL busy_not_queued got=%b want=100", {tx_ready, ps2_clk_oe, rx_inhibit});
    end
    send_byte(8'h3C, 0);
    device_txn(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_set_led();
    test_nack();
    test_patterns();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
